// File: rtl/fir_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : fir_pkg                                                    |
// | Purpose : Shared width derivation and rounding/saturation constants  |
// |           for the streaming FIR and its neighbouring stages.         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package fir_pkg;

  // Ceiling log2. Returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Accumulator width: one product width plus headroom for summing all taps.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + clog2(taps);
  endfunction

  // Value of one half output LSB, expressed in accumulator LSBs.
  function automatic longint half_lsb(input int frac_w);
    return longint'(1) <<< (frac_w - 1);
  endfunction

  // Largest value representable in a signed w-bit field.
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a signed w-bit field.
  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_round_sat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fir_round_sat                                              |
// | Purpose : Round-half-up a fixed-point accumulator by FRAC_W bits and |
// |           clamp the result to a signed OUT_W field, flagging clamps. |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int ACC_W  = 34,
  parameter int FRAC_W = 15,
  parameter int OUT_W  = 14
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat
);

  // One extra bit so adding the half-LSB bias can never wrap.
  localparam int EXT_W = ACC_W + 1;

  localparam logic signed [EXT_W-1:0] c_half = EXT_W'(half_lsb(FRAC_W));
  localparam logic signed [EXT_W-1:0] c_max  = EXT_W'(sat_max(OUT_W));
  localparam logic signed [EXT_W-1:0] c_min  = EXT_W'(sat_min(OUT_W));

  logic signed [EXT_W-1:0] w_biased;
  logic signed [EXT_W-1:0] w_shifted;

  // Bias by half an output LSB, floor-shift, then clamp to the output range.
  always_comb begin
    w_biased  = $signed({acc[ACC_W-1], acc}) + c_half;
    w_shifted = w_biased >>> FRAC_W;
    out_data  = w_shifted[OUT_W-1:0];
    out_sat   = 1'b0;
    if (w_shifted > c_max) begin
      out_data = c_max[OUT_W-1:0];
      out_sat  = 1'b1;
    end else if (w_shifted < c_min) begin
      out_data = c_min[OUT_W-1:0];
      out_sat  = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fir_stream                                                 |
// | Purpose : Direct-form streaming FIR with double-buffered runtime     |
// |           coefficients, two-stage pipeline and valid/ready stall.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fir_stream
  import fir_pkg::*;
#(
  parameter int DATA_W = 14,
  parameter int COEF_W = 16,
  parameter int FRAC_W = 15,
  parameter int TAPS   = 16,
  parameter int OUT_W  = 14
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_W-1:0]    out_data,
  output logic                       out_sat,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  input  logic                       coef_commit
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS);
  localparam int ADDR_W = $clog2(TAPS);

  // The oldest sample only ever feeds the last tap on the cycle it is
  // shifted out, where it is still read from the previous entry, so the
  // stored history needs TAPS-1 entries.
  logic signed [DATA_W-1:0] r_dly    [TAPS-1];
  logic signed [COEF_W-1:0] r_shadow [TAPS];
  logic signed [COEF_W-1:0] r_active [TAPS];
  logic signed [PROD_W-1:0] r_prod   [TAPS];
  logic                     r_s1_valid;

  logic                     w_advance;
  logic                     w_accept;
  logic signed [DATA_W-1:0] w_tap [TAPS];
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [OUT_W-1:0]  w_rs_data;
  logic                     w_rs_sat;

  // Whole pipeline moves together; it only stalls when a result is waiting.
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance && !reset;
  assign w_accept  = in_valid && in_ready;

  // Tap inputs: the incoming sample followed by the stored history.
  always_comb begin
    w_tap[0] = in_data;
    for (int k = 1; k < TAPS; k++) begin
      w_tap[k] = r_dly[k-1];
    end
  end

  // Delay line shifts only when a sample is actually taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TAPS - 1; k++) begin
        r_dly[k] <= '0;
      end
    end else if (w_accept) begin
      r_dly[0] <= in_data;
      for (int k = 1; k < TAPS - 1; k++) begin
        r_dly[k] <= r_dly[k-1];
      end
    end
  end

  // Coefficient banks: writes go to shadow, commit copies the pre-write shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
    end else begin
      if (coef_we && ({1'b0, coef_addr} < (ADDR_W+1)'(TAPS))) begin
        r_shadow[coef_addr] <= coef_data;
      end
      if (coef_commit) begin
        for (int k = 0; k < TAPS; k++) begin
          r_active[k] <= r_shadow[k];
        end
      end
    end
  end

  // Stage 1: register all tap products using the bank active at accept time.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        r_prod[k] <= '0;
      end
    end else if (w_advance) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        for (int k = 0; k < TAPS; k++) begin
          r_prod[k] <= PROD_W'(w_tap[k]) * PROD_W'(r_active[k]);
        end
      end
    end
  end

  // Sign-extended adder tree over the registered products.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < TAPS; k++) begin
      w_sum = w_sum + ACC_W'(r_prod[k]);
    end
  end

  fir_round_sat #(
    .ACC_W  (ACC_W),
    .FRAC_W (FRAC_W),
    .OUT_W  (OUT_W)
  ) u_round_sat (
    .acc      (w_sum),
    .out_data (w_rs_data),
    .out_sat  (w_rs_sat)
  );

  // Stage 2: output register, held while downstream refuses the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (w_advance) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_data <= w_rs_data;
        out_sat  <= w_rs_sat;
      end
    end
  end

endmodule
`default_nettype wire
